// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: frame sequencer for a Viterbi decoder datapath.
// Accepts one symbol at a time, schedules one-cycle ACS steps into a circular
// survivor memory, and issues traceback requests once the window is full and
// a final flush traceback at end of frame.
module viterbi_ctrl #(
  parameter int TB_DEPTH = 15,
  parameter int LEN_W    = 8,
  localparam int PW      = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1,
  localparam int FW      = $clog2(TB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       choose_constraint_length,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             pm_clear,
  output logic             acs_en,
  output logic [PW-1:0]    col_ptr,
  output logic [5:0]       num_states,
  output logic             tb_req,
  input  logic             tb_ack,
  output logic [PW-1:0]    tb_col,
  output logic             tb_flush,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACS, S_TB} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_sym_cnt;
  logic [FW-1:0]    r_fill_cnt;
  logic [PW-1:0]    r_wr_ptr;

  logic w_cfg_ok;
  logic w_xfer;

  assign w_cfg_ok = (choose_constraint_length >= 3'd3) &&
                    (choose_constraint_length <= 3'd6) &&
                    (frame_len != '0);
  // sym_ready is only ever high in RUN, so this is the transfer condition
  assign w_xfer   = sym_ready && sym_valid;

  // Single state machine; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_sym_cnt  <= '0;
      r_fill_cnt <= '0;
      r_wr_ptr   <= '0;
      sym_ready  <= 1'b0;
      pm_clear   <= 1'b0;
      acs_en     <= 1'b0;
      col_ptr    <= '0;
      num_states <= '0;
      tb_req     <= 1'b0;
      tb_col     <= '0;
      tb_flush   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      pm_clear   <= 1'b0;
      acs_en     <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_len      <= frame_len;
              r_sym_cnt  <= '0;
              r_fill_cnt <= '0;
              r_wr_ptr   <= '0;
              cfg_err    <= 1'b0;
              pm_clear   <= 1'b1;
              busy       <= 1'b1;
              // first RUN cycle keeps sym_ready low while metrics clear
              sym_ready  <= 1'b0;
              num_states <= 6'(1) << (choose_constraint_length - 3'd1);
              r_state    <= S_RUN;
            end else begin
              cfg_err    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_state   <= S_ACS;
            sym_ready <= 1'b0;
            acs_en    <= 1'b1;
            col_ptr   <= r_wr_ptr;
            r_wr_ptr  <= (r_wr_ptr == PW'(TB_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            r_sym_cnt <= r_sym_cnt + 1'b1;
            if (r_fill_cnt != FW'(TB_DEPTH))
              r_fill_cnt <= r_fill_cnt + 1'b1;
          end else begin
            sym_ready <= 1'b1;
          end
        end
        S_ACS: begin
          tb_col <= col_ptr;
          // end of frame wins over window-full so the last symbol
          // produces only the flush traceback
          if (r_sym_cnt == r_len) begin
            tb_req   <= 1'b1;
            tb_flush <= 1'b1;
            r_state  <= S_TB;
          end else if (r_fill_cnt == FW'(TB_DEPTH)) begin
            tb_req   <= 1'b1;
            tb_flush <= 1'b0;
            r_state  <= S_TB;
          end else begin
            sym_ready <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_TB: begin
          if (tb_ack) begin
            tb_req   <= 1'b0;
            tb_flush <= 1'b0;
            if (tb_flush) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              num_states <= '0;
              r_state    <= S_IDLE;
            end else begin
              sym_ready  <= 1'b1;
              r_state    <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: table-driven frames, randomized handshakes and hand-written
// stall/reset sequences, checked against a symbol-level event model.
module tb_viterbi_ctrl;
  localparam int D  = 15;
  localparam int LW = 8;
  localparam int PW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    choose_constraint_length = '0;
  logic [LW-1:0] frame_len = '0;
  logic          sym_valid = 1'b0;
  logic          sym_ready;
  logic          pm_clear;
  logic          acs_en;
  logic [PW-1:0] col_ptr;
  logic [5:0]    num_states;
  logic          tb_req;
  logic          tb_ack = 1'b0;
  logic [PW-1:0] tb_col;
  logic          tb_flush;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  viterbi_ctrl #(.TB_DEPTH(D), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .choose_constraint_length(choose_constraint_length),
    .frame_len(frame_len), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .pm_clear(pm_clear), .acs_en(acs_en), .col_ptr(col_ptr),
    .num_states(num_states), .tb_req(tb_req), .tb_ack(tb_ack),
    .tb_col(tb_col), .tb_flush(tb_flush), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int col; bit flush; } tb_ev_t;
  typedef struct { int k; int len; int pv; int pa; bit err; } vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     acs_q[$];
  tb_ev_t tb_q[$];
  int     exp_ns = 0;
  int     done_cnt = 0;
  int     pmc_cnt = 0;
  bit     p_xfer = 0, p_req = 0, p_ack = 0;
  int     p_col = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Symbol-level model: symbol i (1-based) goes to column (i-1) mod D; the last
  // symbol gets a flush traceback, any earlier symbol once D are in gets a
  // normal traceback.
  task automatic build(input int len);
    acs_q.delete();
    tb_q.delete();
    for (int i = 1; i <= len; i++) begin
      acs_q.push_back((i - 1) % D);
      if (i == len)      tb_q.push_back('{(i - 1) % D, 1'b1});
      else if (i >= D)   tb_q.push_back('{(i - 1) % D, 1'b0});
    end
  endtask

  // Observes outputs mid-cycle; values seen here hold through the next posedge
  task automatic mon();
    tb_ev_t e;
    if (rst) begin
      p_xfer = 0; p_req = 0; p_ack = 0;
      return;
    end
    if (pm_clear) begin
      pmc_cnt++;
      chk("ready_during_pmclear", int'(sym_ready), 0);
    end
    if (acs_en || p_xfer) chk("acs_follows_xfer", int'(acs_en), int'(p_xfer));
    if (acs_en) begin
      if (acs_q.size() == 0) fail_now("acs_extra");
      else chk("acs_col", int'(col_ptr), acs_q.pop_front());
      chk("num_states_run", int'(num_states), exp_ns);
    end
    if (tb_req && !p_req) begin
      if (tb_q.size() == 0) fail_now("tb_req_extra");
      else begin
        e = tb_q.pop_front();
        chk("tb_col", int'(tb_col), e.col);
        chk("tb_flush", int'(tb_flush), int'(e.flush));
      end
    end
    if (p_req && !p_ack) begin
      chk("tb_req_hold", int'(tb_req), 1);
      chk("tb_col_hold", int'(tb_col), p_col);
    end
    if (frame_done) done_cnt++;
    p_xfer = sym_ready && sym_valid;
    p_req  = tb_req;
    p_ack  = tb_ack;
    p_col  = int'(tb_col);
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pm_clear"},   int'(pm_clear), 0);
    chk({tag, "_acs_en"},     int'(acs_en), 0);
    chk({tag, "_sym_ready"},  int'(sym_ready), 0);
    chk({tag, "_tb_req"},     int'(tb_req), 0);
    chk({tag, "_tb_flush"},   int'(tb_flush), 0);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_cfg_err"},    int'(cfg_err), 0);
    chk({tag, "_col_ptr"},    int'(col_ptr), 0);
    chk({tag, "_tb_col"},     int'(tb_col), 0);
    chk({tag, "_num_states"}, int'(num_states), 0);
  endtask

  task automatic start_frame(input int k, input int len);
    choose_constraint_length = 3'(k);
    frame_len = LW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int k, input int len, input int pv, input int pa, input bit err);
    int d0, p0, n;
    exp_ns = err ? 0 : (1 << (k - 1));
    if (!err) build(len);
    d0 = done_cnt;
    p0 = pmc_cnt;
    start_frame(k, len);
    chk("cfg_err_after_start", int'(cfg_err), int'(err));
    chk("busy_after_start", int'(busy), int'(!err));
    chk("num_states_start", int'(num_states), exp_ns);
    chk("pm_clear_after_start", int'(pm_clear), int'(!err));
    if (err) begin
      tick();
      chk("pm_clear_count_bad", pmc_cnt - p0, 0);
      chk("busy_bad", int'(busy), 0);
      return;
    end
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      sym_valid = ($urandom_range(0, 99) < pv);
      tb_ack    = ($urandom_range(0, 99) < pa);
      tick();
      n++;
    end
    if (done_cnt == d0) fail_now("frame_timeout");
    sym_valid = 1'b0;
    tb_ack    = 1'b0;
    tick();
    chk("acs_left", acs_q.size(), 0);
    chk("tb_left", tb_q.size(), 0);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("pm_clear_count", pmc_cnt - p0, 1);
    chk("busy_end", int'(busy), 0);
    chk("num_states_end", int'(num_states), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int n, d0, col0;
    bit stalled;

    vecs[0] = '{7, 5, 100, 100, 1};
    vecs[1] = '{2, 5, 100, 100, 1};
    vecs[2] = '{3, 0, 100, 100, 1};
    vecs[3] = '{3, 4, 100, 100, 0};
    vecs[4] = '{3, 20, 100, 100, 0};
    vecs[5] = '{6, 15, 100, 100, 0};
    vecs[6] = '{4, 1, 100, 100, 0};
    vecs[7] = '{0, 9, 100, 100, 1};
    vecs[8] = '{5, 16, 50, 50, 0};
    vecs[9] = '{3, 15, 70, 30, 0};

    repeat (3) tick();
    rst = 1'b0;
    chk_zero("reset");

    foreach (vecs[i])
      run_frame(vecs[i].k, vecs[i].len, vecs[i].pv, vecs[i].pa, vecs[i].err);

    // Traceback stall: ack held low, stray start with bad K must be ignored
    exp_ns = 4;
    build(20);
    d0 = done_cnt;
    start_frame(3, 20);
    sym_valid = 1'b1;
    tb_ack = 1'b0;
    stalled = 0;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      if (tb_req && !stalled) begin
        col0 = int'(tb_col);
        for (int j = 0; j < 10; j++) begin
          start = 1'b1;
          choose_constraint_length = 3'd7;
          tick();
          chk("stall_sym_ready", int'(sym_ready), 0);
          chk("stall_acs_en", int'(acs_en), 0);
          chk("stall_tb_req", int'(tb_req), 1);
          chk("stall_tb_col", int'(tb_col), col0);
        end
        start = 1'b0;
        chk("stall_cfg_err", int'(cfg_err), 0);
        chk("stall_num_states", int'(num_states), 4);
        stalled = 1;
      end
      tb_ack = stalled;
      tick();
      n++;
    end
    if (done_cnt == d0) fail_now("stall_timeout");
    sym_valid = 1'b0;
    tb_ack = 1'b0;
    tick();
    chk("stall_acs_left", acs_q.size(), 0);
    chk("stall_tb_left", tb_q.size(), 0);
    chk("stall_done", done_cnt - d0, 1);

    // Reset while a traceback request is pending aborts the frame
    exp_ns = 8;
    build(20);
    d0 = done_cnt;
    start_frame(4, 20);
    sym_valid = 1'b1;
    tb_ack = 1'b0;
    n = 0;
    while (!tb_req && n < 200) begin
      tick();
      n++;
    end
    chk("rst_seq_tb_req_seen", int'(tb_req), 1);
    rst = 1'b1;
    sym_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk_zero("midreset");
    acs_q.delete();
    tb_q.delete();
    tick();
    chk("midreset_tb_req_stays", int'(tb_req), 0);
    chk("midreset_no_done", done_cnt - d0, 0);
    run_frame(4, 6, 100, 100, 0);

    // Randomized frames
    for (int f = 0; f < 12; f++)
      run_frame($urandom_range(3, 6), $urandom_range(1, 40),
                $urandom_range(30, 100), $urandom_range(20, 100), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
